// File: rtl/dffset_arb.sv
// Two-requester round-robin arbiter owning a shared set-able register.
// Each access takes a fixed IDLE -> GRANT -> RECOVER slot with a one-cycle grant pulse.
module dffset_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       set_req,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             owner,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  state_t           state;
  logic             ptr;
  logic             win;
  logic             cap_set;
  logic [WIDTH-1:0] cap_data;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~ptr;
      default: win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      busy     <= 1'b0;
      owner    <= 1'b0;
      ptr      <= 1'b1;
      cap_set  <= 1'b0;
      cap_data <= '0;
      q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt      <= win ? 2'b10 : 2'b01;
            owner    <= win;
            busy     <= 1'b1;
            cap_set  <= set_req[win];
            cap_data <= win ? wdata1 : wdata0;
            state    <= GRANT;
          end
        end
        // The access is committed from the captured copy, so late input changes are ignored.
        GRANT: begin
          q     <= cap_set ? {WIDTH{1'b1}} : cap_data;
          ptr   <= owner;
          gnt   <= 2'b00;
          state <= RECOVER;
        end
        RECOVER: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
